uart_frame_transceiver: RTL and testbench
=========================================

Name: uart_frame_transceiver

Overview:
- Full-duplex multi-byte frame engine that sits between system logic and the existing byte-level UART core.
- TX side: serialises a variable-length frame of 1..BYTES words into byte-core transmit requests.
- RX side: assembles received words into a BYTES-wide frame, with an inter-byte timeout that delivers partial frames.
- The byte core (baud generation, bit framing) stays external; this block drives and consumes only its byte-level handshake.

Parameters:
- BYTES, 8, max words per frame (2..32).
- DWIDTH, 8, bits per word as carried by the byte core.
- TIMEOUT, 52080, RX inter-byte idle limit in iClock cycles (≈10 bit times at 50 MHz / 9600 baud); must be ≥2.
- LW, $clog2(BYTES+1), derived width of length fields; not overridden.

Ports:
- iClock, in, 1, single system clock; all logic on its rising edge.
- iReset, in, 1, synchronous active-high reset.
- iSendReq, in, 1, one-cycle request to send a frame.
- iSendLen, in, LW, number of words to send; 0 or >BYTES is treated as BYTES.
- iSendDatas, in, BYTES*DWIDTH, frame payload; word 0 = bits [DWIDTH-1:0], sent first.
- oSendBusy, out, 1, TX frame in progress.
- oSendDone, out, 1, one-cycle pulse after the last word's iTxDone.
- oTxStart, out, 1, one-cycle start strobe to the byte core.
- oTxData, out, DWIDTH, word to the byte core.
- iTxDone, in, 1, byte core finished one word (one-cycle pulse).
- iRxData, in, DWIDTH, word from the byte core.
- iRxDone, in, 1, byte core received one word (one-cycle pulse, iRxData valid).
- oRecvReception, out, 1, RX frame partially assembled.
- oRecvDatas, out, BYTES*DWIDTH, last delivered frame; word 0 in the LSBs.
- oRecvLen, out, LW, words valid in oRecvDatas.
- oRecvDone, out, 1, one-cycle pulse: full BYTES-word frame delivered.
- oRecvTimeout, out, 1, one-cycle pulse: partial frame delivered on timeout.

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, shift/assembly buffers, counters and oRecvDatas cleared. Reset mid-frame aborts with no done or timeout pulse.
- TX FSM states IDLE, START, WAIT:
  - IDLE: on iSendReq, latch iSendDatas into the shift register, latch the effective length, clear the sent counter, go to START. iSendReq at cycle n gives oTxStart=1 at n+1.
  - START: oTxStart=1 for exactly one cycle; oTxData = shift[DWIDTH-1:0] (registered, held stable until the next word); go to WAIT.
  - WAIT: on iTxDone, if sent == len-1, pulse oSendDone next cycle and go to IDLE; otherwise shift right by DWIDTH, increment sent, go to START. Gap from iTxDone to the next oTxStart is 1 cycle.
- oSendBusy = (TX state != IDLE); it is 1 in the cycle after iSendReq is accepted and 0 in the cycle oSendDone pulses.
- iSendReq while busy is ignored; the payload and length are not re-latched.
- iTxDone in IDLE or START is ignored.
- RX FSM states IDLE, RECV:
  - iRxDone in IDLE: clear the assembly buffer, store iRxData at word 0, idx=1, clear the timeout counter, go to RECV (oRecvReception=1).
  - iRxDone in RECV: store at word idx, idx+1, clear the timeout counter.
  - When idx reaches BYTES: next cycle, oRecvDatas ← buffer, oRecvLen ← BYTES, oRecvDone=1, return to IDLE, oRecvReception=0.
  - Timeout counter increments every RECV cycle without iRxDone. At TIMEOUT-1: oRecvDatas ← buffer (unfilled words zero), oRecvLen ← idx, oRecvTimeout=1, go to IDLE.
  - iRxDone in the same cycle as timeout expiry: the word is stored, the counter is cleared, and no timeout occurs.
- oRecvDatas and oRecvLen change only on delivery and hold otherwise.
- TX and RX are fully independent; simultaneous activity is legal.

Test Plan:
- Reset, then iSendReq with iSendLen=3, iSendDatas=...0x33_22_11; bench returns iTxDone 100 cycles after each oTxStart -> oTxData 0x11, 0x22, 0x33, each oTxStart 1 cycle after the prior iTxDone; oSendDone pulses once after the third iTxDone; oSendBusy is high throughout.
- iSendLen=0 with BYTES=8 -> 8 words sent, LSB word first; a second iSendReq mid-frame is ignored (payload unchanged, still 8 words).
- Feed 8 iRxDone with 0xA0..0xA7 spaced 5208 cycles -> oRecvDone pulse; oRecvDatas = 0xA7A6A5A4A3A2A1A0; oRecvLen=8; oRecvTimeout never asserts.
- Feed 3 words 0x01, 0x02, 0x03, then idle -> oRecvTimeout pulses TIMEOUT cycles after the last word; oRecvDatas = 0x...000000030201; oRecvLen=3.
- iRxDone coincident with the counter reaching TIMEOUT-1 -> no timeout; idx increments; the frame continues.
- Assert iReset mid-TX (after word 1) and mid-RX (after 4 words) -> all outputs 0 next cycle; no done or timeout pulses; a fresh frame afterwards completes normally.

Source files
------------

// File: rtl/uart_frame_transceiver_if.sv
// Frame-level bundle between system logic, the frame engine and the byte UART core.
// master = system/byte-core side, slave = frame engine.
interface uart_frame_transceiver_if #(
   parameter int BYTES  = 8,
   parameter int DWIDTH = 8,
   parameter int LW     = $clog2(BYTES + 1)
);
   logic                    iSendReq;
   logic [LW-1:0]           iSendLen;
   logic [BYTES*DWIDTH-1:0] iSendDatas;
   logic                    oSendBusy;
   logic                    oSendDone;
   logic                    oTxStart;
   logic [DWIDTH-1:0]       oTxData;
   logic                    iTxDone;
   logic [DWIDTH-1:0]       iRxData;
   logic                    iRxDone;
   logic                    oRecvReception;
   logic [BYTES*DWIDTH-1:0] oRecvDatas;
   logic [LW-1:0]           oRecvLen;
   logic                    oRecvDone;
   logic                    oRecvTimeout;

   modport master (
      output iSendReq, iSendLen, iSendDatas, iTxDone, iRxData, iRxDone,
      input  oSendBusy, oSendDone, oTxStart, oTxData,
      input  oRecvReception, oRecvDatas, oRecvLen, oRecvDone, oRecvTimeout
   );

   modport slave (
      input  iSendReq, iSendLen, iSendDatas, iTxDone, iRxData, iRxDone,
      output oSendBusy, oSendDone, oTxStart, oTxData,
      output oRecvReception, oRecvDatas, oRecvLen, oRecvDone, oRecvTimeout
   );
endinterface

// File: rtl/uart_frame_transceiver.sv
// Multi-word frame engine on top of a byte-level UART core:
// TX serialises 1..BYTES words, RX assembles words with an idle timeout.
module uart_frame_transceiver #(
   parameter int BYTES   = 8,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 52080,
   parameter int LW      = $clog2(BYTES + 1)
) (
   input  logic                     iClock,
   input  logic                     iReset,
   uart_frame_transceiver_if.slave  bus
);
   localparam int FW = BYTES * DWIDTH;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [LW-1:0] L_MAX  = LW'(BYTES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;
   typedef enum logic       {RX_IDLE, RX_RECV}           rx_state_t;

   tx_state_t      r_tx_state, w_tx_next;
   logic [FW-1:0]  r_shift;
   logic [LW-1:0]  r_tx_len;
   logic [LW-1:0]  r_tx_sent;
   logic           r_send_done;
   logic           w_tx_accept;
   logic           w_tx_adv;
   logic           w_tx_last;
   logic [LW-1:0]  w_len_eff;

   assign w_tx_last = (r_tx_sent == r_tx_len - LW'(1));
   assign w_len_eff = (bus.iSendLen == '0 || bus.iSendLen > L_MAX) ?
                      L_MAX : bus.iSendLen;

   always_comb begin
      w_tx_next   = r_tx_state;
      w_tx_accept = 1'b0;
      w_tx_adv    = 1'b0;
      unique case (r_tx_state)
         TX_IDLE: if (bus.iSendReq) begin
            w_tx_accept = 1'b1;
            w_tx_next   = TX_START;
         end
         TX_START: w_tx_next = TX_WAIT;
         TX_WAIT: if (bus.iTxDone) begin
            if (w_tx_last) begin
               w_tx_next = TX_IDLE;
            end else begin
               w_tx_adv  = 1'b1;
               w_tx_next = TX_START;
            end
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_next;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_shift     <= '0;
         r_tx_len    <= '0;
         r_tx_sent   <= '0;
         r_send_done <= 1'b0;
      end else begin
         r_send_done <= (r_tx_state == TX_WAIT) && bus.iTxDone && w_tx_last;
         if (w_tx_accept) begin
            r_shift   <= bus.iSendDatas;
            r_tx_len  <= w_len_eff;
            r_tx_sent <= '0;
         end else if (w_tx_adv) begin
            r_shift   <= r_shift >> DWIDTH;
            r_tx_sent <= r_tx_sent + LW'(1);
         end
      end
   end

   assign bus.oSendBusy = (r_tx_state != TX_IDLE);
   assign bus.oTxStart  = (r_tx_state == TX_START);
   assign bus.oTxData   = r_shift[DWIDTH-1:0];
   assign bus.oSendDone = r_send_done;

   rx_state_t      r_rx_state, w_rx_next;
   logic [FW-1:0]  r_buf, w_buf_next;
   logic [LW-1:0]  r_idx, w_wr_idx;
   logic [TW-1:0]  r_tcnt;
   logic [FW-1:0]  r_recv_datas;
   logic [LW-1:0]  r_recv_len;
   logic           r_recv_done;
   logic           r_recv_tmo;
   logic           w_rx_full;
   logic           w_rx_tmo;

   // A new frame starts from a cleared buffer so short frames read back zero-padded.
   always_comb begin
      w_wr_idx   = (r_rx_state == RX_IDLE) ? '0 : r_idx;
      w_buf_next = (r_rx_state == RX_IDLE) ? '0 : r_buf;
      w_buf_next[w_wr_idx*DWIDTH +: DWIDTH] = bus.iRxData;
   end

   assign w_rx_full = (w_wr_idx == L_MAX - LW'(1));
   assign w_rx_tmo  = (r_rx_state == RX_RECV) && !bus.iRxDone &&
                      (r_tcnt == T_LAST);

   always_comb begin
      w_rx_next = r_rx_state;
      if (bus.iRxDone) w_rx_next = w_rx_full ? RX_IDLE : RX_RECV;
      else if (w_rx_tmo) w_rx_next = RX_IDLE;
   end

   always_ff @(posedge iClock) begin
      if (iReset) r_rx_state <= RX_IDLE;
      else        r_rx_state <= w_rx_next;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_buf        <= '0;
         r_idx        <= '0;
         r_tcnt       <= '0;
         r_recv_datas <= '0;
         r_recv_len   <= '0;
         r_recv_done  <= 1'b0;
         r_recv_tmo   <= 1'b0;
      end else begin
         r_recv_done <= 1'b0;
         r_recv_tmo  <= 1'b0;
         if (bus.iRxDone) begin
            r_buf  <= w_buf_next;
            r_idx  <= w_wr_idx + LW'(1);
            r_tcnt <= '0;
            if (w_rx_full) begin
               r_recv_datas <= w_buf_next;
               r_recv_len   <= L_MAX;
               r_recv_done  <= 1'b1;
            end
         end else if (r_rx_state == RX_RECV) begin
            if (r_tcnt == T_LAST) begin
               r_recv_datas <= r_buf;
               r_recv_len   <= r_idx;
               r_recv_tmo   <= 1'b1;
            end else begin
               r_tcnt <= r_tcnt + TW'(1);
            end
         end
      end
   end

   assign bus.oRecvReception = (r_rx_state == RX_RECV);
   assign bus.oRecvDatas     = r_recv_datas;
   assign bus.oRecvLen       = r_recv_len;
   assign bus.oRecvDone      = r_recv_done;
   assign bus.oRecvTimeout   = r_recv_tmo;
endmodule

// File: tb/tb_uart_frame_transceiver.sv
// Scoreboard bench for uart_frame_transceiver: directed frames queue
// expected words/frames, a negedge monitor pops and compares them.
module tb_uart_frame_transceiver;
   localparam int BYTES   = 8;
   localparam int DWIDTH  = 8;
   localparam int TIMEOUT = 200;
   localparam int LW      = 4;
   localparam int FW      = BYTES * DWIDTH;
   localparam int TXLAT   = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_transceiver_if #(.BYTES(BYTES), .DWIDTH(DWIDTH)) bus ();

   uart_frame_transceiver #(
      .BYTES(BYTES), .DWIDTH(DWIDTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .iClock(clk),
      .iReset(rst),
      .bus   (bus)
   );

   typedef struct {
      logic [DWIDTH-1:0] d;
      bit                first;
   } tx_exp_t;

   typedef struct {
      logic [FW-1:0] d;
      logic [LW-1:0] len;
      bit            tmo;
   } rx_exp_t;

   tx_exp_t txq[$];
   rx_exp_t rxq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_start = 0, n_sdone = 0, n_rxev = 0, n_sdone_exp = 0;
   int last_req = -100, last_txd = -100, last_rxd = -100;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] outs();
      return {bus.oSendBusy, bus.oSendDone, bus.oTxStart, bus.oTxData,
              bus.oRecvReception, bus.oRecvDatas, bus.oRecvLen,
              bus.oRecvDone, bus.oRecvTimeout};
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin : mon
      tx_exp_t te;
      rx_exp_t re;
      if (!rst) begin
         if (bus.iSendReq && !bus.oSendBusy) last_req = cyc;
         if (bus.iTxDone) begin
            last_txd = cyc;
            chk("tx_busy_at_txdone", bus.oSendBusy, 1);
         end
         if (bus.iRxDone) last_rxd = cyc;
         if (bus.oTxStart) begin
            n_start++;
            chk("tx_start_expected", txq.size() > 0, 1);
            if (txq.size() > 0) begin
               te = txq.pop_front();
               chk("tx_data", bus.oTxData, te.d);
               chk("tx_start_gap", cyc, te.first ? last_req + 1 : last_txd + 1);
               chk("tx_busy_at_start", bus.oSendBusy, 1);
            end
         end
         if (bus.oSendDone) begin
            n_sdone++;
            chk("tx_done_expected", n_sdone_exp > 0, 1);
            if (n_sdone_exp > 0) begin
               n_sdone_exp--;
               chk("tx_done_gap", cyc, last_txd + 1);
               chk("tx_busy_at_done", bus.oSendBusy, 0);
               chk("tx_words_left_at_done", txq.size(), 0);
            end
         end
         if (bus.oRecvDone || bus.oRecvTimeout) begin
            n_rxev++;
            chk("rx_event_expected", rxq.size() > 0, 1);
            if (rxq.size() > 0) begin
               re = rxq.pop_front();
               chk("rx_kind", {bus.oRecvDone, bus.oRecvTimeout},
                   re.tmo ? 2'b01 : 2'b10);
               chk("rx_datas", bus.oRecvDatas, re.d);
               chk("rx_len", bus.oRecvLen, re.len);
               chk("rx_reception_low", bus.oRecvReception, 0);
               if (re.tmo) begin
                  total++;
                  if (cyc - last_rxd < TIMEOUT || cyc - last_rxd > TIMEOUT + 1) begin
                     bad++;
                     $display("FAIL rx_timeout_gap: got %0d cycles expected %0d..%0d",
                              cyc - last_rxd, TIMEOUT, TIMEOUT + 1);
                  end
               end
            end
         end
      end
   end

   // byte-core TX responder: iTxDone TXLAT cycles after each oTxStart
   initial begin
      bus.iTxDone = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.oTxStart && !rst) begin
            repeat (TXLAT) @(posedge clk);
            #1 bus.iTxDone = 1'b1;
            @(posedge clk);
            #1 bus.iTxDone = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic push_tx(input logic [FW-1:0] data, input int n);
      logic [FW-1:0] v;
      v = data;
      for (int i = 0; i < n; i++) begin
         txq.push_back('{v[DWIDTH-1:0], i == 0});
         v = v >> DWIDTH;
      end
      n_sdone_exp++;
   endtask

   task automatic send(input logic [LW-1:0] len, input logic [FW-1:0] data);
      @(posedge clk);
      #1 bus.iSendReq = 1'b1;
      bus.iSendLen   = len;
      bus.iSendDatas = data;
      @(posedge clk);
      #1 bus.iSendReq = 1'b0;
   endtask

   task automatic rx_word(input logic [DWIDTH-1:0] d, input int gap);
      repeat (gap) @(posedge clk);
      #1 bus.iRxDone = 1'b1;
      bus.iRxData = d;
      @(posedge clk);
      #1 bus.iRxDone = 1'b0;
   endtask

   task automatic wait_sdone(input int target, input int budget);
      for (int i = 0; i < budget && n_sdone < target; i++) @(posedge clk);
      #1 chk("tx_done_within_budget", n_sdone >= target, 1);
   endtask

   task automatic wait_rx(input int target, input int budget);
      for (int i = 0; i < budget && n_rxev < target; i++) @(posedge clk);
      #1 chk("rx_event_within_budget", n_rxev >= target, 1);
   endtask

   initial begin
      int base;
      bus.iSendReq   = 1'b0;
      bus.iSendLen   = '0;
      bus.iSendDatas = '0;
      bus.iRxData    = '0;
      bus.iRxDone    = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", outs(), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // 3-word frame: 0x11, 0x22, 0x33; word 3 (0x44) must not go out
      push_tx(64'hEEDDCCBB_44332211, 3);
      send(4'd3, 64'hEEDDCCBB_44332211);
      wait_sdone(1, 3 * (TXLAT + 10) + 20);
      chk("tx_start_count_len3", n_start, 3);

      // len 0 -> 8 words; a request mid-frame is ignored
      push_tx(64'h88878685_84838281, 8);
      send(4'd0, 64'h88878685_84838281);
      for (int i = 0; i < 400 && n_start < 5; i++) @(posedge clk);
      send(4'd2, 64'hFFFFFFFF_FFFFFFFF);
      wait_sdone(2, 8 * (TXLAT + 10) + 50);
      chk("tx_start_count_len0", n_start, 11);

      // len > BYTES -> 8 words
      push_tx(64'h08070605_04030201, 8);
      send(4'd15, 64'h08070605_04030201);
      wait_sdone(3, 8 * (TXLAT + 10) + 50);
      chk("tx_start_count_len15", n_start, 19);

      // full RX frame
      rxq.push_back('{64'hA7A6A5A4_A3A2A1A0, 4'd8, 1'b0});
      for (int i = 0; i < 8; i++) rx_word(8'hA0 + 8'(i), (i == 0) ? 0 : 19);
      wait_rx(1, 50);

      // partial frame delivered on timeout
      rxq.push_back('{64'h00000000_00030201, 4'd3, 1'b1});
      rx_word(8'h01, 4);
      rx_word(8'h02, 4);
      rx_word(8'h03, 4);
      wait_rx(2, TIMEOUT + 50);
      repeat (20) @(posedge clk);
      #1 chk("rx_datas_hold", bus.oRecvDatas, 64'h00000000_00030201);
      chk("rx_len_hold", bus.oRecvLen, 3);

      // word arriving exactly at expiry keeps the frame alive
      rxq.push_back('{64'hB7B6B5B4_B3B2B1B0, 4'd8, 1'b0});
      rx_word(8'hB0, 3);
      rx_word(8'hB1, TIMEOUT - 1);
      #1 chk("rx_coincident_still_recv", bus.oRecvReception, 1);
      chk("rx_coincident_no_event", n_rxev, 2);
      for (int i = 2; i < 8; i++) rx_word(8'hB0 + 8'(i), 3);
      wait_rx(3, 50);

      // reset after the first word of a TX frame
      base = n_start;
      txq.push_back('{8'hD1, 1'b1});
      send(4'd4, 64'h00000000_D4D3D2D1);
      for (int i = 0; i < 3000 && !bus.iTxDone; i++) #1;
      chk("tx_abort_txdone_seen", bus.iTxDone, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("reset_mid_tx_outputs", outs(), 0);
      rst = 1'b0;
      repeat (TXLAT + 20) @(posedge clk);
      chk("tx_abort_no_more_starts", n_start, base + 1);
      chk("tx_abort_no_done", n_sdone, 3);
      txq.delete();
      n_sdone_exp = 0;
      push_tx(64'h00000000_0000E2E1, 2);
      send(4'd2, 64'h00000000_0000E2E1);
      wait_sdone(4, 2 * (TXLAT + 10) + 20);

      // reset after 4 received words
      for (int i = 0; i < 4; i++) rx_word(8'hC0 + 8'(i), 3);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 chk("reset_mid_rx_outputs", outs(), 0);
      rst = 1'b0;
      repeat (TIMEOUT + 20) @(posedge clk);
      chk("rx_abort_no_event", n_rxev, 3);
      rxq.push_back('{64'hC7C6C5C4_C3C2C1C0, 4'd8, 1'b0});
      for (int i = 0; i < 8; i++) rx_word(8'hC0 + 8'(i), 3);
      wait_rx(4, 50);

      repeat (5) @(posedge clk);
      chk("tx_queue_drained", txq.size(), 0);
      chk("rx_queue_drained", rxq.size(), 0);
      chk("tx_done_all_seen", n_sdone_exp, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
